// File: rtl/seg7_scan_reader_if.sv
// Bus between a scanned seven-segment display tap and the scan reader.
// Slave side is the reader; master side drives segments/strobes and consumes frames.
interface seg7_scan_reader_if;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_N = 4;

    logic [SEG_W-1:0]   seg_in;
    logic [DIG_N-1:0]   dig_en;
    logic               out_ready;
    logic [4*DIG_N-1:0] digits;
    logic               out_valid;
    logic               frame_err;
    logic               overrun;

    modport master (
        output seg_in, dig_en, out_ready,
        input  digits, out_valid, frame_err, overrun
    );

    modport slave (
        input  seg_in, dig_en, out_ready,
        output digits, out_valid, frame_err, overrun
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Seven-segment scan reader: debounces a multiplexed 4-digit display and emits decoded frames.
// Optional feature macro SEG7_BLANK_ACCEPT_EN: an all-dark digit is legal and decodes to 4'hF.
module seg7_scan_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_reader_if.slave bus
);
    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_N = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIG_N-1:0]   ref_en_q, ref_en_d;
    logic [SEG_W-1:0]   ref_seg_q, ref_seg_d;
    logic [DIG_N-1:0]   fill_q, fill_d;
    logic [DIG_N-1:0]   err_buf_q, err_buf_d;
    logic [4*DIG_N-1:0] buf_q, buf_d;
    logic [4*DIG_N-1:0] digits_q, digits_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    logic               one_hot_c;
    logic               same_c;
    logic               capture_c;
    logic [4:0]         dec_c;

    // Returns {illegal, value}.
    function automatic logic [4:0] decode(input logic [SEG_W-1:0] seg);
        case (seg)
            7'b1111110: decode = {1'b0, 4'd0};
            7'b0110000: decode = {1'b0, 4'd1};
            7'b1101101: decode = {1'b0, 4'd2};
            7'b1111001: decode = {1'b0, 4'd3};
            7'b0110011: decode = {1'b0, 4'd4};
            7'b1011011: decode = {1'b0, 4'd5};
            7'b1011111: decode = {1'b0, 4'd6};
            7'b1110000: decode = {1'b0, 4'd7};
            7'b1111111: decode = {1'b0, 4'd8};
            7'b1111011: decode = {1'b0, 4'd9};
`ifdef SEG7_BLANK_ACCEPT_EN
            7'b0000000: decode = {1'b0, 4'hF};
`endif
            default:    decode = {1'b1, 4'hE};
        endcase
    endfunction

    assign one_hot_c = $onehot(bus.dig_en);
    assign same_c    = (bus.dig_en == ref_en_q) && (bus.seg_in == ref_seg_q);
    assign dec_c     = decode(ref_seg_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ref_en_d    = ref_en_q;
        ref_seg_d   = ref_seg_q;
        fill_d      = fill_q;
        err_buf_d   = err_buf_q;
        buf_d       = buf_q;
        digits_d    = digits_q;
        out_valid_d = out_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        capture_c   = 1'b0;

        // Stability tracking: any change of strobe or segments restarts the count.
        case (state_q)
            IDLE: begin
                if (one_hot_c) begin
                    ref_en_d  = bus.dig_en;
                    ref_seg_d = bus.seg_in;
                    cnt_d     = CNT_W'(1);
                    state_d   = SETTLE;
                end else begin
                    cnt_d = '0;
                end
            end
            SETTLE, HELD: begin
                if (!same_c) begin
                    if (one_hot_c) begin
                        ref_en_d  = bus.dig_en;
                        ref_seg_d = bus.seg_in;
                        cnt_d     = CNT_W'(1);
                        state_d   = SETTLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (state_q == SETTLE) begin
                    cnt_d = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
                    if (cnt_d == CNT_MAX) begin
                        capture_c = 1'b1;
                        state_d   = HELD;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A full fill mask is presented one edge after the last capture, or dropped if blocked.
        if (fill_q == '1) begin
            fill_d = '0;
            if (!out_valid_q || bus.out_ready) begin
                digits_d    = buf_q;
                frame_err_d = |err_buf_q;
                out_valid_d = 1'b1;
                overrun_d   = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if (capture_c) begin
            for (int i = 0; i < int'(DIG_N); i++) begin
                if (ref_en_q[i]) begin
                    buf_d[4*i +: 4] = dec_c[3:0];
                    err_buf_d[i]    = dec_c[4];
                end
            end
            fill_d = fill_d | ref_en_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ref_en_q    <= '0;
            ref_seg_q   <= '0;
            fill_q      <= '0;
            err_buf_q   <= '0;
            buf_q       <= '0;
            digits_q    <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_en_q    <= ref_en_d;
            ref_seg_q   <= ref_seg_d;
            fill_q      <= fill_d;
            err_buf_q   <= err_buf_d;
            buf_q       <= buf_d;
            digits_q    <= digits_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.digits    = digits_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scenarios plus random scanning against a run-length model.
module tb_seg7_scan_reader;
    localparam int unsigned STABLE = 4;
    localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1111011};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_reader_if bus ();

    seg7_scan_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the digit table; returns {illegal, value}.
    function automatic logic [4:0] ref_decode(input logic [6:0] seg);
        for (int i = 0; i < 10; i++)
            if (seg == PAT[i]) return {1'b0, 4'(i)};
`ifdef SEG7_BLANK_ACCEPT_EN
        if (seg == 7'd0) return {1'b0, 4'hF};
`endif
        return {1'b1, 4'hE};
    endfunction

    // Model: a digit is captured on the edge its identical one-hot sample run reaches STABLE.
    logic [3:0]  m_dig [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0]  m_err = '0;
    logic [3:0]  m_fill = '0;
    int          run_len = 0;
    logic [10:0] prev = '0;
    logic [15:0] e_digits = '0;
    logic        e_valid = 1'b0;
    logic        e_ferr = 1'b0;
    logic        e_ovr = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [10:0] cur;
        logic [4:0]  d;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_dig[i] = '0;
            m_err = '0; m_fill = '0; run_len = 0; prev = '0;
            e_digits = '0; e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
        end else begin
            if (m_fill == 4'hF) begin
                m_fill = '0;
                if (!e_valid || bus.out_ready) begin
                    e_digits = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
                    e_ferr   = |m_err;
                    e_valid  = 1'b1;
                    e_ovr    = 1'b0;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (e_valid && bus.out_ready) begin
                e_valid = 1'b0;
                e_ovr   = 1'b0;
            end
            cur = {bus.dig_en, bus.seg_in};
            if ($countones(bus.dig_en) == 1)
                run_len = (cur == prev && run_len > 0) ? run_len + 1 : 1;
            else
                run_len = 0;
            prev = cur;
            if (run_len == int'(STABLE)) begin
                d = ref_decode(bus.seg_in);
                for (int i = 0; i < 4; i++) begin
                    if (bus.dig_en[i]) begin
                        m_dig[i]  = d[3:0];
                        m_err[i]  = d[4];
                        m_fill[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("digits", bus.digits, e_digits);
        cmp("out_valid", 16'(bus.out_valid), 16'(e_valid));
        cmp("frame_err", 16'(bus.frame_err), 16'(e_ferr));
        cmp("overrun", 16'(bus.overrun), 16'(e_ovr));
    end

    // Hold a strobe/segment pair for n sampling edges; returns 1ns after the last edge.
    task automatic drive(input logic [3:0] en, input logic [6:0] seg, input int n);
        bus.dig_en = en;
        bus.seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input int a, input int b, input int c, input int e, input int n);
        drive(4'b0001, PAT[a], n);
        drive(4'b0010, PAT[b], n);
        drive(4'b0100, PAT[c], n);
        drive(4'b1000, PAT[e], n);
    endtask

    initial begin
        logic [3:0] en;
        logic [6:0] seg;
        int         r;
        bus.seg_in = '0; bus.dig_en = '0; bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_digits", bus.digits, 16'h0000);
        cmp("reset_valid", 16'(bus.out_valid), 16'h0);
        cmp("reset_ovr", 16'(bus.overrun), 16'h0);
        rst_n = 1'b1;
        drive(4'b0000, 7'd0, 2);

        // Basic scan 1,2,3,4 with consumer ready.
        drive(4'b0001, PAT[1], 6);
        drive(4'b0010, PAT[2], 6);
        drive(4'b0100, PAT[3], 6);
        drive(4'b1000, PAT[4], 4);
        cmp("scan_no_valid_at_capture", 16'(bus.out_valid), 16'h0);
        drive(4'b1000, PAT[4], 1);
        cmp("scan_valid", 16'(bus.out_valid), 16'h1);
        cmp("scan_digits", bus.digits, 16'h4321);
        cmp("scan_model_pin", e_digits, 16'h4321);
        cmp("scan_ferr", 16'(bus.frame_err), 16'h0);
        drive(4'b1000, PAT[4], 1);
        drive(4'b0000, 7'd0, 2);

        // Short hold on slot 2 must not capture.
        drive(4'b0001, PAT[5], 5);
        drive(4'b0010, PAT[6], 5);
        drive(4'b0100, PAT[7], 3);
        drive(4'b1000, PAT[8], 5);
        drive(4'b0001, PAT[5], 5);
        drive(4'b0010, PAT[6], 5);
        drive(4'b0000, 7'd0, 2);
        cmp("short_hold_no_frame", 16'(bus.out_valid), 16'h0);
        drive(4'b0100, PAT[7], 4);
        cmp("short_hold_capture_latency", 16'(bus.out_valid), 16'h0);
        drive(4'b0100, PAT[7], 1);
        cmp("short_hold_valid", 16'(bus.out_valid), 16'h1);
        cmp("short_hold_digits", bus.digits, 16'h8765);
        drive(4'b0000, 7'd0, 2);

        // Illegal pattern on slot 1.
        drive(4'b0001, PAT[0], 5);
        drive(4'b0010, 7'b1000001, 5);
        drive(4'b0100, PAT[0], 5);
        drive(4'b1000, PAT[0], 5);
        cmp("illegal_digits", bus.digits, 16'h00E0);
        cmp("illegal_ferr", 16'(bus.frame_err), 16'h1);
        drive(4'b0000, 7'd0, 2);

        // All-dark digit on slot 1.
        drive(4'b0001, PAT[0], 5);
        drive(4'b0010, 7'b0000000, 5);
        drive(4'b0100, PAT[0], 5);
        drive(4'b1000, PAT[0], 5);
`ifdef SEG7_BLANK_ACCEPT_EN
        cmp("blank_digits", bus.digits, 16'h00F0);
        cmp("blank_ferr", 16'(bus.frame_err), 16'h0);
`else
        cmp("blank_digits", bus.digits, 16'h00E0);
        cmp("blank_ferr", 16'(bus.frame_err), 16'h1);
`endif
        drive(4'b0000, 7'd0, 2);

        // Overrun: second frame completes while the first is still held.
        bus.out_ready = 1'b0;
        scan4(9, 8, 7, 6, 6);
        cmp("ovr_first_valid", 16'(bus.out_valid), 16'h1);
        cmp("ovr_first_digits", bus.digits, 16'h6789);
        scan4(1, 1, 1, 1, 6);
        drive(4'b0000, 7'd0, 2);
        cmp("ovr_digits_held", bus.digits, 16'h6789);
        cmp("ovr_valid_held", 16'(bus.out_valid), 16'h1);
        cmp("ovr_set", 16'(bus.overrun), 16'h1);
        bus.out_ready = 1'b1;
        drive(4'b0000, 7'd0, 1);
        cmp("ovr_valid_cleared", 16'(bus.out_valid), 16'h0);
        cmp("ovr_cleared", 16'(bus.overrun), 16'h0);

        // Asynchronous reset mid-frame with a held frame on the outputs.
        bus.out_ready = 1'b0;
        scan4(1, 2, 3, 4, 6);
        drive(4'b0001, PAT[5], 5);
        drive(4'b0010, PAT[6], 5);
        cmp("pre_reset_valid", 16'(bus.out_valid), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_digits", bus.digits, 16'h0000);
        cmp("async_rst_valid", 16'(bus.out_valid), 16'h0);
        cmp("async_rst_ferr", 16'(bus.frame_err), 16'h0);
        cmp("async_rst_ovr", 16'(bus.overrun), 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(4'b0100, PAT[3], 5);
        drive(4'b1000, PAT[4], 5);
        drive(4'b0000, 7'd0, 3);
        cmp("post_rst_partial", 16'(bus.out_valid), 16'h0);
        drive(4'b0001, PAT[1], 5);
        drive(4'b0010, PAT[2], 5);
        cmp("post_rst_valid", 16'(bus.out_valid), 16'h1);
        cmp("post_rst_digits", bus.digits, 16'h4321);

        // Random scanning, glitches, illegal patterns, back-pressure and occasional resets.
        for (int k = 0; k < 400; k++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) en = 4'(1) << $urandom_range(0, 3);
            else en = 4'($urandom_range(0, 15));
            r = int'($urandom_range(0, 9));
            if (r < 7)      seg = PAT[$urandom_range(0, 9)];
            else if (r < 9) seg = 7'($urandom_range(0, 127));
            else            seg = 7'd0;
            drive(en, seg, int'($urandom_range(1, 7)));
            if ($urandom_range(0, 79) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        bus.out_ready = 1'b1;
        drive(4'b0000, 7'd0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
